// File: rtl/usb_spi_master.sv
// SPI master (mode 0, MSB first) feeding the external USB host chip.
// Bytes arrive on a valid/ready stream. Chip select stays low from the first
// accepted byte until the byte flagged last has been shifted. Each received
// byte is presented as a one-cycle rx_valid_out pulse.
module usb_spi_master #(
  parameter int unsigned CLK_DIV = 2  // SCLK half-period in clk_in cycles, 1..255
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] tx_data_in,
  input  logic       tx_valid_in,
  input  logic       tx_last_in,
  output logic       tx_ready_out,
  output logic [7:0] rx_data_out,
  output logic       rx_valid_out,
  output logic       busy_out,
  output logic       done_out,
  input  logic       miso_in,
  output logic       sclk_out,
  output logic       mosi_out,
  output logic       ss_out
);

  typedef enum logic [2:0] {
    S_GAP,
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [7:0] DIV_LAST  = 8'(CLK_DIV - 1);
  localparam logic [4:0] EDGE_LAST = 5'd16;

  state_t     r_state;
  logic [7:0] r_div_cnt;   // clk_in cycles spent in the current half-period
  logic [4:0] r_edge_cnt;  // SCLK edges produced so far for this byte
  logic [7:0] r_tx_shift;  // bit 6 is the next bit to put on MOSI
  logic [7:0] r_rx_shift;  // MISO bits collected MSB first
  logic       r_last;      // current byte closes the transaction

  logic w_div_done;
  logic w_accept;

  assign w_div_done = (r_div_cnt == DIV_LAST);

  // Ready is decoded from state. In the cycle that rx_valid_out is high the
  // machine already sits in WAIT, but the next byte is only taken one cycle
  // later so the byte period stays 17*CLK_DIV+2.
  assign tx_ready_out = (r_state == S_IDLE) ||
                        ((r_state == S_WAIT) && !rx_valid_out);
  assign w_accept     = tx_valid_in && tx_ready_out;

  // Transfer sequencer: state, counters, shift registers and all SPI/stream outputs.
  // NOTE: every register here is updated with <= so all of them see the
  // pre-edge values; a blocking = would let later lines observe the new state.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= S_GAP;
      r_div_cnt    <= 8'd0;
      r_edge_cnt   <= 5'd0;
      r_tx_shift   <= 8'd0;
      r_rx_shift   <= 8'd0;
      r_last       <= 1'b0;
      ss_out       <= 1'b1;
      sclk_out     <= 1'b0;
      mosi_out     <= 1'b0;
      rx_data_out  <= 8'd0;
      rx_valid_out <= 1'b0;
      done_out     <= 1'b0;
      busy_out     <= 1'b0;
    end else begin
      // NOTE: pulse outputs default low each cycle and are raised only by the
      // branch that produces the event, which keeps them exactly one cycle wide.
      rx_valid_out <= 1'b0;
      done_out     <= 1'b0;

      case (r_state)
        // Minimum deselect time after reset and between transactions.
        S_GAP: begin
          if (w_div_done) begin
            r_div_cnt <= 8'd0;
            r_state   <= S_IDLE;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        // IDLE opens a transaction; WAIT continues one with SS still low.
        S_IDLE, S_WAIT: begin
          if (w_accept) begin
            r_tx_shift <= tx_data_in;
            r_last     <= tx_last_in;
            mosi_out   <= tx_data_in[7];
            ss_out     <= 1'b0;
            busy_out   <= 1'b1;
            r_div_cnt  <= 8'd0;
            r_state    <= S_SETUP;
          end
        end

        // MOSI bit 7 settles for one half-period before the first rise.
        S_SETUP: begin
          if (w_div_done) begin
            r_div_cnt  <= 8'd0;
            sclk_out   <= 1'b1;
            r_rx_shift <= {r_rx_shift[6:0], miso_in};
            r_edge_cnt <= 5'd1;
            r_state    <= S_SHIFT;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        // Sixteen SCLK edges, then one more low half-period before the byte
        // is reported, which gives the slave hold time on bit 0.
        S_SHIFT: begin
          if (w_div_done) begin
            r_div_cnt <= 8'd0;
            if (r_edge_cnt == EDGE_LAST) begin
              rx_valid_out <= 1'b1;
              rx_data_out  <= r_rx_shift;
              r_state      <= r_last ? S_HOLD : S_WAIT;
            end else begin
              sclk_out   <= ~sclk_out;
              r_edge_cnt <= r_edge_cnt + 5'd1;
              if (!sclk_out) begin
                r_rx_shift <= {r_rx_shift[6:0], miso_in};
              end else if (r_edge_cnt != EDGE_LAST - 5'd1) begin
                // Falls 1..7 present the next bit; the fall after bit 0 keeps it.
                mosi_out   <= r_tx_shift[6];
                r_tx_shift <= {r_tx_shift[6:0], 1'b0};
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        // Chip-select hold after the final byte, then release.
        S_HOLD: begin
          if (w_div_done) begin
            r_div_cnt <= 8'd0;
            ss_out    <= 1'b1;
            busy_out  <= 1'b0;
            done_out  <= 1'b1;
            r_state   <= S_GAP;
          end else begin
            r_div_cnt <= r_div_cnt + 8'd1;
          end
        end

        default: begin
          r_state <= S_GAP;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_spi_master.sv
// Directed bench for usb_spi_master: one instance with CLK_DIV=2 driven by a
// scripted SPI slave, one with CLK_DIV=1 with MISO looped back to MOSI.
module tb_usb_spi_master;

  logic clk;
  logic rst_n;

  logic       a_tx_valid, a_tx_last, a_tx_ready, a_rx_valid, a_busy, a_done;
  logic       a_miso, a_sclk, a_mosi, a_ss;
  logic [7:0] a_tx_data, a_rx_data;

  logic       b_tx_valid, b_tx_last, b_tx_ready, b_rx_valid, b_busy, b_done;
  logic       b_sclk, b_mosi, b_ss;
  logic [7:0] b_tx_data, b_rx_data;

  usb_spi_master #(.CLK_DIV(2)) u_dut_a (
    .clk_in(clk), .rst_in(rst_n),
    .tx_data_in(a_tx_data), .tx_valid_in(a_tx_valid), .tx_last_in(a_tx_last),
    .tx_ready_out(a_tx_ready), .rx_data_out(a_rx_data), .rx_valid_out(a_rx_valid),
    .busy_out(a_busy), .done_out(a_done), .miso_in(a_miso),
    .sclk_out(a_sclk), .mosi_out(a_mosi), .ss_out(a_ss)
  );

  usb_spi_master #(.CLK_DIV(1)) u_dut_b (
    .clk_in(clk), .rst_in(rst_n),
    .tx_data_in(b_tx_data), .tx_valid_in(b_tx_valid), .tx_last_in(b_tx_last),
    .tx_ready_out(b_tx_ready), .rx_data_out(b_rx_data), .rx_valid_out(b_rx_valid),
    .busy_out(b_busy), .done_out(b_done), .miso_in(b_mosi),
    .sclk_out(b_sclk), .mosi_out(b_mosi), .ss_out(b_ss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scripted slave: bit stream presented MSB first, advanced after each SCLK rise.
  logic [31:0] slave_stream = 32'h0;
  int          rise_base    = 0;
  int          a_rise_cnt   = 0;

  always_comb begin
    a_miso = 1'b0;
    if (a_rise_cnt >= rise_base && (a_rise_cnt - rise_base) < 32)
      a_miso = slave_stream[5'(31 - (a_rise_cnt - rise_base))];
  end

  // Event logs, sampled on the falling clk edge.
  int a_mosi_q[$], a_rx_t[$], a_rx_d[$], a_done_t[$], a_ss_rise_t[$];
  int b_rise_t[$], b_rx_t[$], b_rx_d[$], b_done_t[$];
  logic a_sclk_prev = 1'b0, a_ss_prev = 1'b1, b_sclk_prev = 1'b0;
  int   busy_err = 0;

  always @(negedge clk) begin
    if (a_sclk && !a_sclk_prev) begin
      a_mosi_q.push_back(int'(a_mosi));
      a_rise_cnt <= a_rise_cnt + 1;
    end
    a_sclk_prev <= a_sclk;
    if (a_ss && !a_ss_prev) a_ss_rise_t.push_back(cyc);
    a_ss_prev <= a_ss;
    if (a_rx_valid) begin
      a_rx_t.push_back(cyc);
      a_rx_d.push_back(int'(a_rx_data));
    end
    if (a_done) a_done_t.push_back(cyc);
    if (b_sclk && !b_sclk_prev) b_rise_t.push_back(cyc);
    b_sclk_prev <= b_sclk;
    if (b_rx_valid) begin
      b_rx_t.push_back(cyc);
      b_rx_d.push_back(int'(b_rx_data));
    end
    if (b_done) b_done_t.push_back(cyc);
    if ((a_busy !== ~a_ss) || (b_busy !== ~b_ss)) busy_err <= busy_err + 1;
  end

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i >= 0 && i < q.size()) ? q[i] : -1;
  endfunction

  function automatic int mosi_byte(input int base);
    int b = 0;
    for (int i = 0; i < 8; i++) b = (b << 1) | qget(a_mosi_q, base + i);
    return b;
  endfunction

  // Called at a falling edge: present a byte and wait for the handshake.
  // t is the accept cycle; returns at the falling edge of the following cycle
  // with tx_valid still high.
  task automatic send(input bit sel, input logic [7:0] d, input bit last, output int t);
    int budget = 0;
    if (!sel) begin
      a_tx_data = d; a_tx_last = last; a_tx_valid = 1'b1;
    end else begin
      b_tx_data = d; b_tx_last = last; b_tx_valid = 1'b1;
    end
    while (!(sel ? b_tx_ready : a_tx_ready) && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    t = cyc;
    if (budget >= 300) check("send_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic wait_ready(input bit sel, output int t);
    int budget = 0;
    while (!(sel ? b_tx_ready : a_tx_ready) && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    t = cyc;
    if (budget >= 300) check("ready_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] slave;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t vecs[4];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t, t1, t2, t3, tr, mb, rb, db, sb, budget;
    int ss_bad, sclk_bad, rdy_bad, acc_t;

    vecs[0] = '{tx: 8'h91, slave: 8'hA5, exp_rx: 8'hA5, exp_mosi: 8'h91};
    vecs[1] = '{tx: 8'h00, slave: 8'hFF, exp_rx: 8'hFF, exp_mosi: 8'h00};
    vecs[2] = '{tx: 8'hFF, slave: 8'h00, exp_rx: 8'h00, exp_mosi: 8'hFF};
    vecs[3] = '{tx: 8'h5A, slave: 8'h3C, exp_rx: 8'h3C, exp_mosi: 8'h5A};

    rst_n = 1'b0;
    a_tx_data = 8'h00; a_tx_valid = 1'b0; a_tx_last = 1'b0;
    b_tx_data = 8'h00; b_tx_valid = 1'b0; b_tx_last = 1'b0;

    // Reset values and ready timing after release.
    repeat (3) @(negedge clk);
    check("rst_ss", int'(a_ss), 1);
    check("rst_sclk", int'(a_sclk), 0);
    check("rst_mosi", int'(a_mosi), 0);
    check("rst_rx_data", int'(a_rx_data), 0);
    check("rst_rx_valid", int'(a_rx_valid), 0);
    check("rst_done", int'(a_done), 0);
    check("rst_busy", int'(a_busy), 0);
    check("rst_ready", int'(a_tx_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready_a_c1", int'(a_tx_ready), 0);
    check("rel_ready_b_c1", int'(b_tx_ready), 1);
    @(negedge clk);
    check("rel_ready_a_c2", int'(a_tx_ready), 1);

    // Single-byte transactions at CLK_DIV=2.
    foreach (vecs[i]) begin
      mb = a_mosi_q.size(); rb = a_rx_t.size(); db = a_done_t.size(); sb = a_ss_rise_t.size();
      rise_base = a_rise_cnt;
      slave_stream = {vecs[i].slave, 24'h0};
      send(1'b0, vecs[i].tx, 1'b1, t);
      a_tx_valid = 1'b0;
      wait_ready(1'b0, tr);
      check($sformatf("v%0d_rx_count", i), a_rx_t.size() - rb, 1);
      check($sformatf("v%0d_rx_time", i), qget(a_rx_t, rb) - t, 35);
      check($sformatf("v%0d_rx_data", i), qget(a_rx_d, rb), int'(vecs[i].exp_rx));
      check($sformatf("v%0d_rises", i), a_mosi_q.size() - mb, 8);
      check($sformatf("v%0d_mosi", i), mosi_byte(mb), int'(vecs[i].exp_mosi));
      check($sformatf("v%0d_done_time", i), qget(a_done_t, db) - t, 37);
      check($sformatf("v%0d_ss_rise_time", i), qget(a_ss_rise_t, sb) - t, 37);
      check($sformatf("v%0d_ready_again", i), tr - t, 39);
    end

    // Back-to-back with tx_valid held high.
    mb = a_mosi_q.size(); rb = a_rx_t.size(); db = a_done_t.size(); sb = a_ss_rise_t.size();
    rise_base = a_rise_cnt;
    slave_stream = 32'hABCDEF00;
    send(1'b0, 8'h12, 1'b0, t1);
    send(1'b0, 8'h34, 1'b0, t2);
    send(1'b0, 8'h56, 1'b1, t3);
    a_tx_valid = 1'b0;
    wait_ready(1'b0, tr);
    check("b2b_accept_gap1", t2 - t1, 36);
    check("b2b_accept_gap2", t3 - t2, 36);
    check("b2b_rx_count", a_rx_t.size() - rb, 3);
    check("b2b_rx_time0", qget(a_rx_t, rb) - t1, 35);
    check("b2b_rx_gap1", qget(a_rx_t, rb + 1) - qget(a_rx_t, rb), 36);
    check("b2b_rx_gap2", qget(a_rx_t, rb + 2) - qget(a_rx_t, rb + 1), 36);
    check("b2b_rx0", qget(a_rx_d, rb), 'hAB);
    check("b2b_rx1", qget(a_rx_d, rb + 1), 'hCD);
    check("b2b_rx2", qget(a_rx_d, rb + 2), 'hEF);
    check("b2b_rises", a_mosi_q.size() - mb, 24);
    check("b2b_mosi0", mosi_byte(mb), 'h12);
    check("b2b_mosi1", mosi_byte(mb + 8), 'h34);
    check("b2b_mosi2", mosi_byte(mb + 16), 'h56);
    check("b2b_done_count", a_done_t.size() - db, 1);
    check("b2b_ss_rise_count", a_ss_rise_t.size() - sb, 1);

    // Stalled stream: 50 idle cycles in WAIT between two bytes.
    mb = a_mosi_q.size(); rb = a_rx_t.size(); db = a_done_t.size(); sb = a_ss_rise_t.size();
    rise_base = a_rise_cnt;
    slave_stream = 32'h817E0000;
    send(1'b0, 8'hFF, 1'b0, t1);
    a_tx_valid = 1'b0;
    budget = 0;
    while (!a_rx_valid && budget < 100) begin
      @(negedge clk);
      budget++;
    end
    check("stall_first_rx_seen", int'(a_rx_valid), 1);
    @(negedge clk);
    ss_bad = 0; sclk_bad = 0; rdy_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (a_ss !== 1'b0) ss_bad++;
      if (a_sclk !== 1'b0) sclk_bad++;
      if (a_tx_ready !== 1'b1) rdy_bad++;
      @(negedge clk);
    end
    send(1'b0, 8'h00, 1'b1, t2);
    a_tx_valid = 1'b0;
    wait_ready(1'b0, tr);
    check("stall_ss_low", ss_bad, 0);
    check("stall_sclk_low", sclk_bad, 0);
    check("stall_ready_high", rdy_bad, 0);
    check("stall_rx_count", a_rx_t.size() - rb, 2);
    check("stall_rx0", qget(a_rx_d, rb), 'h81);
    check("stall_rx1", qget(a_rx_d, rb + 1), 'h7E);
    check("stall_rx1_time", qget(a_rx_t, rb + 1) - t2, 35);
    check("stall_mosi0", mosi_byte(mb), 'hFF);
    check("stall_mosi1", mosi_byte(mb + 8), 'h00);
    check("stall_done_count", a_done_t.size() - db, 1);
    check("stall_ss_rise_count", a_ss_rise_t.size() - sb, 1);

    // Ready discipline: data changes every cycle while the block is busy.
    mb = a_mosi_q.size(); rb = a_rx_t.size();
    rise_base = a_rise_cnt;
    slave_stream = 32'h0;
    send(1'b0, 8'h6B, 1'b0, t1);
    acc_t = -1;
    for (int i = 0; i < 100; i++) begin
      a_tx_data  = 8'hC0 ^ 8'(i);
      a_tx_last  = 1'b1;
      a_tx_valid = 1'b1;
      if (a_tx_ready) begin
        acc_t = cyc;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    a_tx_valid = 1'b0;
    wait_ready(1'b0, tr);
    check("rdy_accept_cycle", acc_t - t1, 36);
    check("rdy_rx_count", a_rx_t.size() - rb, 2);
    check("rdy_mosi0", mosi_byte(mb), 'h6B);
    check("rdy_mosi1", mosi_byte(mb + 8), 'hE3);

    // CLK_DIV=1 with MISO looped back to MOSI.
    send(1'b1, 8'h3C, 1'b1, t);
    b_tx_valid = 1'b0;
    wait_ready(1'b1, tr);
    check("div1_rx_count", b_rx_t.size(), 1);
    check("div1_rx_data", qget(b_rx_d, 0), 'h3C);
    check("div1_rx_time", qget(b_rx_t, 0) - t, 18);
    check("div1_done_time", qget(b_done_t, 0) - t, 19);
    check("div1_rises", b_rise_t.size(), 8);
    check("div1_first_rise", qget(b_rise_t, 0) - t, 2);
    check("div1_sclk_period", qget(b_rise_t, 1) - qget(b_rise_t, 0), 2);
    check("div1_ready_again", tr - t, 20);

    // Reset in the middle of a byte.
    rb = a_rx_t.size(); db = a_done_t.size();
    slave_stream = 32'hFFFFFFFF;
    rise_base = a_rise_cnt;
    send(1'b0, 8'h91, 1'b1, t);
    a_tx_valid = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ss", int'(a_ss), 1);
    check("midrst_sclk", int'(a_sclk), 0);
    check("midrst_mosi", int'(a_mosi), 0);
    check("midrst_busy", int'(a_busy), 0);
    check("midrst_ready", int'(a_tx_ready), 0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_c1", int'(a_tx_ready), 0);
    @(negedge clk);
    check("midrst_ready_c2", int'(a_tx_ready), 1);
    repeat (40) @(negedge clk);
    check("midrst_no_rx", a_rx_t.size() - rb, 0);
    check("midrst_no_done", a_done_t.size() - db, 0);
    check("busy_eq_not_ss", busy_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
